// File: rtl/prog_mem.sv
// Writable program memory for the CPU fetch path: byte-stream loader with an
// auto-incrementing pointer plus a one-cycle-latency request/response fetch port.
module prog_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_end,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err
);

  localparam int              IDX_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [0:0]      ST_RUN  = 1'b0;
  localparam logic [0:0]      ST_LOAD = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, ready_q;
  logic              fvalid_q, fvalid_d;
  logic [DATA_W-1:0] fdata_q, fdata_d, rd_data_s;
  logic              ferr_q, ferr_d;
  logic              wr_en_s, accept_s, in_range_s;
  logic [IDX_W-1:0]  wr_idx_s;

  // Load-side next state; the pointer doubles as the written-word count.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q[IDX_W-1:0];
    if (load_start) begin
      // A restart always lands its first word at address 0, even from RUN.
      state_d  = ST_LOAD;
      ovf_d    = 1'b0;
      wr_en_s  = load_valid;
      wr_idx_s = {IDX_W{1'b0}};
      ptr_d    = load_valid ? PTR_ONE : {(ADDR_W+1){1'b0}};
    end else if (state_q == ST_LOAD) begin
      if (load_valid && (ptr_q < DEPTH_C)) begin
        wr_en_s = 1'b1;
        ptr_d   = ptr_q + PTR_ONE;
      end else if (load_valid) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      state_d = load_end ? ST_RUN : ST_LOAD;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Fetch-side next state; out-of-range requests answer zero with an error flag.
  always_comb begin
    accept_s   = fetch_req & ready_q;
    in_range_s = ({1'b0, fetch_addr} < DEPTH_C);
    if (in_range_s) begin
      rd_data_s = mem_q[fetch_addr[IDX_W-1:0]];
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
    fvalid_d = accept_s;
    if (accept_s) begin
      fdata_d = rd_data_s;
      ferr_d  = ~in_range_s;
    end else begin
      fdata_d = fdata_q;
      ferr_d  = ferr_q;
    end
  end

  // Storage array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= load_data;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      ptr_q    <= {(ADDR_W+1){1'b0}};
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      fvalid_q <= 1'b0;
      fdata_q  <= {DATA_W{1'b0}};
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d == ST_LOAD);
      ready_q  <= (state_d == ST_RUN);
      fvalid_q <= fvalid_d;
      fdata_q  <= fdata_d;
      ferr_q   <= ferr_d;
    end
  end

  assign load_busy   = busy_q;
  assign load_count  = ptr_q;
  assign load_ovf    = ovf_q;
  assign fetch_ready = ready_q;
  assign fetch_valid = fvalid_q;
  assign fetch_data  = fdata_q;
  assign fetch_err   = ferr_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed self-checking bench for prog_mem with DEPTH = 16.
module tb_prog_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start, load_valid, load_end;
  logic [7:0] load_data;
  logic       load_busy, load_ovf;
  logic [8:0] load_count;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ready, fetch_valid, fetch_err;
  logic [7:0] fetch_data;

  int checks = 0;
  int failures = 0;

  prog_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_end(load_end), .load_busy(load_busy), .load_count(load_count),
    .load_ovf(load_ovf), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; load_data = 8'h00;
    fetch_req = 1'b0; fetch_addr = 8'h00;
  endtask

  task automatic fetch(input logic [7:0] addr, input logic [7:0] exp_d,
                       input logic exp_e, input string tag);
    fetch_req = 1'b1; fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_data"}, 32'(fetch_data), 32'(exp_d));
    check({tag, "_err"}, 32'(fetch_err), 32'(exp_e));
  endtask

  logic [7:0] words [4];

  initial begin
    words[0] = 8'h05; words[1] = 8'h0A; words[2] = 8'hFF; words[3] = 8'h80;

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_start = 1'($urandom); load_valid = 1'($urandom); load_end = 1'($urandom);
      load_data = 8'($urandom); fetch_req = 1'($urandom); fetch_addr = 8'($urandom);
      tick();
    end
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_ready", 32'(fetch_ready), 32'd1);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_data", 32'(fetch_data), 32'h00);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_ovf", 32'(load_ovf), 32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // Load four words.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ld_busy", 32'(load_busy), 32'd1);
    check("ld_ready", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = words[i];
      tick();
    end
    load_valid = 1'b0; load_end = 1'b1;
    tick();
    load_end = 1'b0;
    check("ld_count", 32'(load_count), 32'd4);
    check("ld_done_busy", 32'(load_busy), 32'd0);
    check("ld_done_ready", 32'(fetch_ready), 32'd1);

    // Back-to-back fetches of 0..3.
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = 8'(i);
      tick();
      check("b2b_valid", 32'(fetch_valid), 32'd1);
      check("b2b_data", 32'(fetch_data), 32'(words[i]));
      check("b2b_err", 32'(fetch_err), 32'd0);
    end
    fetch_req = 1'b0;
    tick();
    check("b2b_idle_valid", 32'(fetch_valid), 32'd0);
    check("b2b_hold_data", 32'(fetch_data), 32'h80);

    // Overflow: 17 words into a 16-word array.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ovf_restart_count", 32'(load_count), 32'd0);
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1; load_data = 8'(i);
      tick();
      if (i == 15) check("ovf_pre_flag", 32'(load_ovf), 32'd0);
    end
    load_valid = 1'b0;
    check("ovf_count", 32'(load_count), 32'd16);
    check("ovf_flag", 32'(load_ovf), 32'd1);
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    check("ovf_sticky", 32'(load_ovf), 32'd1);
    fetch(8'h00, 8'h00, 1'b0, "ovf_f0");
    fetch(8'h0F, 8'h0F, 1'b0, "ovf_f15");

    // Out-of-range and boundary addresses.
    fetch(8'h10, 8'h00, 1'b1, "oor_10");
    fetch(8'h0F, 8'h0F, 1'b0, "inr_0f");
    fetch(8'hFF, 8'h00, 1'b1, "oor_ff");

    // Restart collisions.
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hAA;
    tick();
    idle();
    check("rs1_count", 32'(load_count), 32'd1);
    check("rs1_ovf_clr", 32'(load_ovf), 32'd0);
    tick();
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'h55;
    tick();
    idle();
    check("rs2_count", 32'(load_count), 32'd1);
    fetch_req = 1'b1; fetch_addr = 8'h00;
    tick();
    check("blk_valid_a", 32'(fetch_valid), 32'd0);
    tick();
    check("blk_valid_b", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0; load_end = 1'b1;
    tick();
    load_end = 1'b0;
    check("rs_count", 32'(load_count), 32'd1);
    check("rs_busy", 32'(load_busy), 32'd0);
    fetch(8'h00, 8'h55, 1'b0, "rs_f0");
    fetch(8'h01, 8'h01, 1'b0, "rs_f1");

    // load_start + load_end together, with a fetch accepted in the same cycle.
    load_start = 1'b1; load_end = 1'b1; fetch_req = 1'b1; fetch_addr = 8'h00;
    tick();
    idle();
    check("se_busy", 32'(load_busy), 32'd1);
    check("se_ready", 32'(fetch_ready), 32'd0);
    check("se_fvalid", 32'(fetch_valid), 32'd1);
    check("se_fdata", 32'(fetch_data), 32'h55);
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    check("se_exit_busy", 32'(load_busy), 32'd0);

    // Reset during a load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h11;
    tick();
    load_data = 8'h22;
    tick();
    load_valid = 1'b0;
    check("mid_count_pre", 32'(load_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(load_busy), 32'd0);
    check("mid_ready", 32'(fetch_ready), 32'd1);
    check("mid_count", 32'(load_count), 32'd0);
    check("mid_data", 32'(fetch_data), 32'h00);
    #2 rst_n = 1'b1;
    tick();
    fetch(8'h00, 8'h11, 1'b0, "mid_f0");
    fetch(8'h01, 8'h22, 1'b0, "mid_f1");
    fetch(8'h02, 8'h02, 1'b0, "mid_f2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised program memory for the 88bit CPU fetch path. It replaces fixed, hard-coded program contents with a writable array. A byte-stream load port fills the array from address 0 with an auto-incrementing pointer. A request/response fetch port returns instruction words one cycle after the request. The block sits between the boot/host loader and the CPU instruction-fetch stage.

## Interface
Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 8, fetch address width in bits.
- DEPTH, 256, number of implemented words; legal range 2 ≤ DEPTH ≤ 2^ADDR_W.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse: enter LOAD, pointer := 0, clear load_ovf.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  word to write at the load pointer.
- load_end  in  1  pulse: leave LOAD and return to RUN.
- load_busy  out  1  high while in LOAD.
- load_count  out  ADDR_W+1  number of words written since the last load_start; saturates at DEPTH.
- load_ovf  out  1  sticky: a write was attempted with pointer = DEPTH.
- fetch_req  in  1  fetch request; accepted only when fetch_ready = 1.
- fetch_addr  in  ADDR_W  word address of the request.
- fetch_ready  out  1  high in RUN; low in LOAD.
- fetch_valid  out  1  one-cycle pulse marking a fetch response.
- fetch_data  out  DATA_W  response word; holds its value between responses.
- fetch_err  out  1  qualifies fetch_valid: the request address was ≥ DEPTH.

## Operation
- States: RUN and LOAD. Reset state is RUN.
- RUN → LOAD on load_start. LOAD → RUN on load_end. load_start while in LOAD restarts: pointer := 0, count := 0, ovf := 0.
- In LOAD, when load_valid = 1 and pointer < DEPTH: write mem[pointer] := load_data, then pointer +1 and count +1.
- In LOAD, when load_valid = 1 and pointer = DEPTH: drop the write and set load_ovf. The pointer and count hold.
- load_valid in RUN is ignored.
- Same-cycle load_start + load_valid (from either state): the data is written at address 0; pointer and count become 1.
- Same-cycle load_valid + load_end: the write is performed, then the block exits to RUN.
- Same-cycle load_start + load_end: load_start wins; the block is in LOAD afterwards.
- Fetch is accepted when fetch_req & fetch_ready. The address is sampled at acceptance.
  - In range: fetch_data := mem[addr], fetch_err := 0.
  - Out of range: fetch_data := 0, fetch_err := 1.
- Memory array is not reset. Contents survive rst_n. Words never written since power-up read as undefined.
- Reset values: load_busy 0, load_count 0, load_ovf 0, fetch_ready 1, fetch_valid 0, fetch_data 0, fetch_err 0. Internal pointer is 0.

## Timing
- Fetch latency is 1 cycle: a request accepted at edge N produces fetch_valid = 1 and fetch_data after edge N+1.
- Throughput is one fetch per cycle; back-to-back requests give back-to-back responses.
- fetch_ready is registered from state. It goes low in the cycle after load_start is sampled and high in the cycle after load_end is sampled.
- A fetch accepted in the same cycle as load_start still completes normally one cycle later.
- A load write at edge N is visible to a fetch accepted at edge N+1 or later. No bypass is needed, since fetch is blocked during LOAD.
- load_busy, load_count and load_ovf update on the edge that samples the corresponding input.
- Reset asserted mid-load: all outputs go to their reset values immediately (asynchronous). Words already written remain. Any in-flight fetch response is cancelled.

## Test plan
- Reset: hold rst_n = 0 with random inputs → load_busy 0, fetch_ready 1, fetch_valid 0, fetch_data 0x00, load_count 0.
- Load then fetch: load_start, then 4 words 0x05, 0x0A, 0xFF, 0x80, then load_end. Required: load_count = 4. Fetch addresses 0, 1, 2, 3 on consecutive cycles → fetch_valid on 4 consecutive cycles with data 0x05, 0x0A, 0xFF, 0x80 and fetch_err = 0.
- Out-of-range (DEPTH = 16): fetch address 0x10 → fetch_data 0x00, fetch_err 1, one cycle after acceptance. Fetch address 0x0F → stored word, fetch_err 0.
- Overflow (DEPTH = 16): load 17 words 0x00..0x10 → load_count 16 and load_ovf 1. Fetch address 0 → 0x00; fetch address 15 → 0x0F.
- Restart and collision:
  - load_start + load_valid(0xAA) in the same cycle, then a second load_start + load_valid(0x55) two cycles later, then load_end. Required: load_count = 1, fetch address 0 → 0x55.
  - fetch_req asserted during LOAD → no fetch_valid.
- Reset mid-load: assert rst_n = 0 after 2 of 4 words → state RUN and load_count 0. Fetch of the 2 written addresses returns the written data.
